// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the CPU two-phase clock sequencer:
// state encoding, per-state CLK1/CLK2 levels and reset output levels.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    BOOT_LO,
    BOOT_HI,
    IDLE,
    PH1_HI,
    PH1_LO,
    PH2_LO,
    PH2_HI
  } seq_state_e;

  typedef struct packed {
    logic clk1;
    logic clk2;
  } phase_lvl_t;

  localparam phase_lvl_t LVL_BOOT_LO = '{clk1: 1'b0, clk2: 1'b0};
  localparam phase_lvl_t LVL_BOOT_HI = '{clk1: 1'b0, clk2: 1'b1};
  localparam phase_lvl_t LVL_IDLE    = '{clk1: 1'b0, clk2: 1'b1};
  localparam phase_lvl_t LVL_PH1_HI  = '{clk1: 1'b1, clk2: 1'b1};
  localparam phase_lvl_t LVL_PH1_LO  = '{clk1: 1'b0, clk2: 1'b1};
  localparam phase_lvl_t LVL_PH2_LO  = '{clk1: 1'b0, clk2: 1'b0};
  localparam phase_lvl_t LVL_PH2_HI  = '{clk1: 1'b0, clk2: 1'b1};

  localparam logic RST_CLK1   = 1'b0;
  localparam logic RST_CLK2   = 1'b1;
  localparam logic RST_BOOT   = 1'b1;
  localparam logic RST_HALTED = 1'b0;

  // Clock levels driven while the sequencer sits in a given state.
  function automatic phase_lvl_t state_lvl(input seq_state_e s);
    phase_lvl_t lvl;
    lvl = LVL_IDLE;
    unique case (s)
      BOOT_LO: lvl = LVL_BOOT_LO;
      BOOT_HI: lvl = LVL_BOOT_HI;
      IDLE:    lvl = LVL_IDLE;
      PH1_HI:  lvl = LVL_PH1_HI;
      PH1_LO:  lvl = LVL_PH1_LO;
      PH2_LO:  lvl = LVL_PH2_LO;
      PH2_HI:  lvl = LVL_PH2_HI;
      default: lvl = LVL_IDLE;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/cpu_phase_timer.sv
// Phase timer: reloads PHASE_CYC-1 on state entry and counts down;
// expire_c flags the last cycle of the current phase.
module cpu_phase_timer #(
  parameter int unsigned PHASE_CYC = 2
) (
  input  logic CLK,
  input  logic reset,
  input  logic load,
  output logic expire_c
);

  localparam int unsigned TW = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(PHASE_CYC - 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      cnt <= RELOAD;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - TW'(1);
    end
  end

  assign expire_c = (cnt == '0);

endmodule

// File: rtl/cpu_phase_sequencer.sv
// Two-phase CLK1/CLK2 sequencer with boot sequence, run/step/halt control
// and instruction counter. Breakpoint stop enabled by CPU_SEQ_BREAKPOINT_EN.
module cpu_phase_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int unsigned PHASE_CYC = 2,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned AUTO_RUN  = 0
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             halt_req,
  input  logic [7:0]       Addr,
  input  logic [7:0]       bp_addr,
  input  logic             bp_valid,
  output logic             CLK1,
  output logic             CLK2,
  output logic             boot,
  output logic             halted,
  output logic             bp_hit,
  output logic [CNT_W-1:0] instr_cnt
);

  seq_state_e state, state_next;
  phase_lvl_t lvl_c;
  logic expire_c, load_c, boundary_c, leave_idle_c, start_c;
  logic bp_match_c, continue_c;
  logic halt_pend, step_mode;

  cpu_phase_timer #(.PHASE_CYC(PHASE_CYC)) u_timer (
    .CLK      (CLK),
    .reset    (reset),
    .load     (load_c),
    .expire_c (expire_c)
  );

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= BOOT_LO;
    else       state <= state_next;
  end

  // Back-to-back execution only in free-running mode with nothing asking to stop.
  assign continue_c = run && !halt_pend && !halt_req && !step_mode && !bp_match_c;

  always_comb begin
    state_next   = state;
    boundary_c   = 1'b0;
    leave_idle_c = 1'b0;
    unique case (state)
      BOOT_LO: if (expire_c) state_next = BOOT_HI;
      BOOT_HI: if (expire_c) state_next = ((AUTO_RUN != 0) && run) ? PH1_HI : IDLE;
      IDLE: begin
        if (!halt_req && (step || run)) begin
          state_next   = PH1_HI;
          leave_idle_c = 1'b1;
        end
      end
      PH1_HI:  if (expire_c) state_next = PH1_LO;
      PH1_LO:  if (expire_c) state_next = PH2_LO;
      PH2_LO:  if (expire_c) state_next = PH2_HI;
      PH2_HI: begin
        if (expire_c) begin
          boundary_c = 1'b1;
          state_next = continue_c ? PH1_HI : IDLE;
        end
      end
      default: state_next = BOOT_LO;
    endcase
  end

  assign load_c  = (state_next != state);
  assign start_c = leave_idle_c || ((state == BOOT_HI) && (state_next == PH1_HI));
  assign lvl_c   = state_lvl(state);

  // Output levels lag the state by one cycle so every pin is a clean flop.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      CLK1      <= RST_CLK1;
      CLK2      <= RST_CLK2;
      boot      <= RST_BOOT;
      halted    <= RST_HALTED;
      instr_cnt <= '0;
      halt_pend <= 1'b0;
      step_mode <= 1'b0;
    end else begin
      CLK1   <= lvl_c.clk1;
      CLK2   <= lvl_c.clk2;
      boot   <= (state == BOOT_LO) || (state == BOOT_HI);
      halted <= (state == IDLE);
      if (boundary_c) instr_cnt <= instr_cnt + CNT_W'(1);
      if (start_c) step_mode <= leave_idle_c && step;
      if (boundary_c && (state_next == IDLE)) halt_pend <= 1'b0;
      else if (halt_req && (state != IDLE))   halt_pend <= 1'b1;
    end
  end

`ifdef CPU_SEQ_BREAKPOINT_EN
  assign bp_match_c = bp_valid && (Addr == bp_addr) && !step_mode;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset)                          bp_hit <= 1'b0;
    else if (start_c)                   bp_hit <= 1'b0;
    else if (boundary_c && bp_match_c)  bp_hit <= 1'b1;
  end
`else
  logic unused_bp_c;
  assign unused_bp_c = ^{Addr, bp_addr, bp_valid};
  assign bp_match_c  = 1'b0;
  assign bp_hit      = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Scoreboard bench for cpu_phase_sequencer: random step/run/halt transactions,
// expected idle-entry records queued by the stimulus and checked by a monitor.
module tb_cpu_phase_sequencer;

  localparam int unsigned PC = 2;
  localparam int unsigned CW = 4;
  localparam int IP = 4 * PC;
`ifdef CPU_SEQ_BREAKPOINT_EN
  localparam bit BP_EN = 1'b1;
`else
  localparam bit BP_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic reset, run, step, halt_req, bp_valid;
  logic [7:0] Addr, bp_addr;
  logic CLK1, CLK2, boot, halted, bp_hit;
  logic [CW-1:0] instr_cnt;

  typedef struct {
    int cnt;
    bit bp;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   exp_cnt = 0;
  bit   boot_pend = 1'b0;

  cpu_phase_sequencer #(.PHASE_CYC(PC), .CNT_W(CW), .AUTO_RUN(0)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .run       (run),
    .step      (step),
    .halt_req  (halt_req),
    .Addr      (Addr),
    .bp_addr   (bp_addr),
    .bp_valid  (bp_valid),
    .CLK1      (CLK1),
    .CLK2      (CLK2),
    .boot      (boot),
    .halted    (halted),
    .bp_hit    (bp_hit),
    .instr_cnt (instr_cnt)
  );

  initial forever #5 CLK = ~CLK;

  function automatic void check(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endfunction

  // Monitor: waveform legality, phase widths, and scoreboard pop on each IDLE entry.
  initial begin
    logic p1, p2, ph;
    int hi_len, lo_len;
    bit hi_ok, lo_ok;
    exp_t e;
    p1 = 1'b0; p2 = 1'b1; ph = 1'b0;
    hi_len = 0; lo_len = 0; hi_ok = 1'b0; lo_ok = 1'b0;
    forever begin
      @(negedge CLK);
      if (reset) begin
        hi_ok = 1'b0; lo_ok = 1'b0;
      end else begin
        check("clk1_without_clk2", int'(CLK1 && !CLK2), 0);
        check("single_edge", int'(CLK1 != p1) + int'(CLK2 != p2) <= 1 ? 1 : 0, 1);
        if (CLK1 && !p1) begin hi_len = 1; hi_ok = 1'b1; end
        else if (CLK1) hi_len++;
        else if (p1 && hi_ok) check("clk1_high_width", hi_len, PC);
        if (!CLK2 && p2) begin lo_len = 1; lo_ok = 1'b1; end
        else if (!CLK2) lo_len++;
        else if (!p2 && lo_ok) check("clk2_low_width", lo_len, PC);
        if (halted && !ph) begin
          if (sb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL idle_event: unexpected IDLE entry, cnt %0d at %0t", instr_cnt, $time);
          end else begin
            e = sb.pop_front();
            check("sb_instr_cnt", int'(instr_cnt), e.cnt);
            check("sb_bp_hit", int'(bp_hit), int'(e.bp));
          end
        end
      end
      p1 = CLK1; p2 = CLK2; ph = halted;
    end
  end

  // Release reset and follow the boot sequence cycle by cycle.
  task automatic do_boot(input bit halt_in_boot);
    sb.push_back('{cnt: 0, bp: 1'b0});
    @(negedge CLK);
    reset = 1'b0;
    #1;
    check("boot_rel_clk2", int'(CLK2), 1);
    check("boot_rel_halted", int'(halted), 0);
    for (int i = 1; i <= 5; i++) begin
      @(posedge CLK);
      #1;
      if (i <= 4) begin
        check("boot_clk2", int'(CLK2), (i <= 2) ? 0 : 1);
        check("boot_sel", int'(boot), 1);
      end else begin
        check("boot_release", int'(boot), 0);
        check("boot_halted", int'(halted), 1);
      end
      halt_req = halt_in_boot && (i == 1);
    end
    halt_req  = 1'b0;
    boot_pend = halt_in_boot;
  endtask

  // kind: 0 step, 1 step+halt same cycle, 2 run then drop, 3 run then halt_req
  task automatic txn(input int kind);
    int n, d, h, len;
    bit bp;
    Addr     = 8'($urandom_range(0, 3));
    bp_valid = 1'($urandom_range(0, 1));
    bp = 1'b0; h = -1; d = 0; n = 0;
    case (kind)
      0: n = 1;
      1: n = 0;
      2: begin d = $urandom_range(1, 30); n = 1 + (d - 1) / IP; end
      default: begin h = $urandom_range(1, 24); n = (h + IP - 1) / IP; d = IP * n + 1; end
    endcase
    if (kind >= 2) begin
      bp = BP_EN && bp_valid && (Addr == bp_addr);
      if (bp || boot_pend) begin n = 1; d = IP + 1; h = -1; end
    end
    if (n > 0) begin
      boot_pend = 1'b0;
      exp_cnt = (exp_cnt + n) % (1 << CW);
      sb.push_back('{cnt: exp_cnt, bp: bp});
    end
    len = (n > 0) ? IP * n + 2 : 6;
    for (int c = 0; c < len; c++) begin
      @(negedge CLK);
      step     = (kind <= 1) && (c == 0);
      halt_req = ((kind == 1) && (c == 0)) || (c == h);
      run      = (kind >= 2) && (c < d);
      @(posedge CLK);
      #1;
      if (n > 0 && c == 0) check("clk1_low_at_start", int'(CLK1), 0);
      if (n > 0 && c == 1) check("clk1_rise_latency", int'(CLK1), 1);
      if (n > 0 && c == len - 2) check("busy_before_boundary", int'(halted), 0);
    end
    @(negedge CLK);
    step = 1'b0; halt_req = 1'b0; run = 1'b0;
    check("idle_after_txn", int'(halted), 1);
    check("cnt_after_txn", int'(instr_cnt), exp_cnt);
    check("bp_after_txn", int'(bp_hit), int'(bp));
  endtask

  // Reset in the middle of an instruction, then a boot with a latched halt_req.
  task automatic mid_reset();
    @(negedge CLK);
    step = 1'b1;
    @(negedge CLK);
    step = 1'b0;
    repeat ($urandom_range(1, 7)) @(posedge CLK);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_clk1", int'(CLK1), 0);
    check("mid_rst_clk2", int'(CLK2), 1);
    check("mid_rst_boot", int'(boot), 1);
    check("mid_rst_halted", int'(halted), 0);
    check("mid_rst_cnt", int'(instr_cnt), 0);
    check("mid_rst_bp", int'(bp_hit), 0);
    exp_cnt = 0;
    repeat (2) @(posedge CLK);
    do_boot(1'b1);
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; step = 1'b0; halt_req = 1'b0;
    bp_valid = 1'b0; bp_addr = 8'd3; Addr = 8'd0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_clk1", int'(CLK1), 0);
    check("rst_clk2", int'(CLK2), 1);
    check("rst_boot", int'(boot), 1);
    check("rst_halted", int'(halted), 0);
    check("rst_bp_hit", int'(bp_hit), 0);
    check("rst_cnt", int'(instr_cnt), 0);
    do_boot(1'b0);
    txn(0);
    txn(1);
    txn(3);
    for (int i = 0; i < 40; i++) begin
      if (i == 20) mid_reset();
      txn($urandom_range(0, 3));
    end
    repeat (4) @(negedge CLK);
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
